// File: rtl/nibble_tx_if.sv
// nibble_tx_if: load handshake and serial line for the 4-bit nibble transmitter.
//   En    - load request from the sender (sampled only while Ready=1)
//   Din   - data word, bit 0 is the MSB and is sent first
//   TxD   - serial line, idles high
//   Ready - transmitter can accept a word
//   Busy  - frame on the line (always ~Ready)
//   Done  - one-cycle pulse at frame completion
// The master modport is the word source; the slave modport is the transmitter.
interface nibble_tx_if;
    logic       En;
    logic [0:3] Din;
    logic       TxD;
    logic       Ready;
    logic       Busy;
    logic       Done;

    modport master (output En, Din, input TxD, Ready, Busy, Done);
    modport slave  (input En, Din, output TxD, Ready, Busy, Done);
endinterface

// File: rtl/nibble_tx.sv
// nibble_tx: serial transmitter for 4-bit words.
// Frame on TxD: start(0), Din[0], Din[1], Din[2], Din[3], even parity, stop(1);
// every bit lasts BAUD_DIV clock cycles (legal range 1..256).
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset; aborts a frame in progress
//   bus - nibble_tx_if.slave (En/Din in, TxD/Ready/Busy/Done out)
// All outputs come straight from flops.
module nibble_tx #(
    parameter int BAUD_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    nibble_tx_if.slave   bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Counter reload; BAUD_DIV=256 gives 255, the top of the 8-bit counter.
    localparam logic [7:0] BAUD_RELOAD = 8'(BAUD_DIV - 1);

    logic [2:0] state_reg;
    logic [7:0] baud_cnt_reg;
    logic [1:0] bit_cnt_reg;
    logic [0:3] data_reg;
    logic       parity_reg;
    logic       txd_reg;
    logic       ready_reg;
    logic       busy_reg;
    logic       done_reg;

    logic       bit_end;
    logic [1:0] bit_cnt_next;

    assign bit_end      = (baud_cnt_reg == 8'd0);
    assign bit_cnt_next = bit_cnt_reg + 2'd1;   // wraps 3 -> 0 on DATA exit

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= 8'd0;
            bit_cnt_reg  <= 2'd0;
            data_reg     <= 4'b0000;
            parity_reg   <= 1'b0;
            txd_reg      <= 1'b1;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            // Outside IDLE the counter runs down; a state or bit ends at 0.
            if (state_reg != ST_IDLE) begin
                baud_cnt_reg <= bit_end ? BAUD_RELOAD : baud_cnt_reg - 8'd1;
            end

            // TxD is loaded with the value of the state being entered so the
            // line changes on the same edge as the state register.
            case (state_reg)
                ST_IDLE: begin
                    if (bus.En) begin
                        data_reg     <= bus.Din;
                        parity_reg   <= ^bus.Din;
                        baud_cnt_reg <= BAUD_RELOAD;
                        bit_cnt_reg  <= 2'd0;
                        state_reg    <= ST_START;
                        txd_reg      <= 1'b0;
                        ready_reg    <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_reg <= ST_DATA;
                        txd_reg   <= data_reg[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt_reg <= bit_cnt_next;
                        if (bit_cnt_reg == 2'd3) begin
                            state_reg <= ST_PARITY;
                            txd_reg   <= parity_reg;
                        end else begin
                            txd_reg   <= data_reg[bit_cnt_next];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_reg <= ST_STOP;
                        txd_reg   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state_reg    <= ST_IDLE;
                        baud_cnt_reg <= 8'd0;
                        ready_reg    <= 1'b1;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encodings fall back to a quiet idle line.
                    state_reg    <= ST_IDLE;
                    baud_cnt_reg <= 8'd0;
                    bit_cnt_reg  <= 2'd0;
                    txd_reg      <= 1'b1;
                    ready_reg    <= 1'b1;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TxD   = txd_reg;
    assign bus.Ready = ready_reg;
    assign bus.Busy  = busy_reg;
    assign bus.Done  = done_reg;

endmodule

// File: tb/tb_nibble_tx.sv
// Testbench for nibble_tx: two instances (BAUD_DIV=4 and BAUD_DIV=1) run side by
// side. A reference model keeps, per instance, the list of line values still to
// be shown for the frame in flight; every cycle all outputs are compared.
module tb_nibble_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4;
    logic rst1;

    nibble_tx_if if4 ();
    nibble_tx_if if1 ();

    nibble_tx #(.BAUD_DIV(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));
    nibble_tx #(.BAUD_DIV(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state: instance 0 is BAUD_DIV=4, instance 1 is BAUD_DIV=1.
    bit exp_bits [2][0:63];
    int rd       [2];
    int len      [2];
    bit mdone    [2];
    int baud     [2];

    int done1_times [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic exp_tx(input int i);
        return (rd[i] < len[i]) ? exp_bits[i][rd[i]] : 1'b1;
    endfunction

    function automatic logic exp_ready(input int i);
        return (rd[i] == len[i]);
    endfunction

    // Advance the model by one rising edge with the inputs seen at that edge.
    task automatic model_edge(input int i, input logic r, input logic en, input logic [0:3] d);
        logic [0:6] frame;
        if (r) begin
            rd[i] = 0; len[i] = 0; mdone[i] = 1'b0;
        end else if (rd[i] < len[i]) begin
            rd[i]++;
            mdone[i] = (rd[i] == len[i]);
        end else begin
            mdone[i] = 1'b0;
            if (en) begin
                frame = {1'b0, d, ^d, 1'b1};
                rd[i] = 0; len[i] = 0;
                for (int j = 0; j < 7; j++)
                    for (int c = 0; c < baud[i]; c++) begin
                        exp_bits[i][len[i]] = frame[j];
                        len[i]++;
                    end
                $display("dut%0d accept din=%b cycle %0d", baud[i], d, cyc);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0, rst4, if4.En, if4.Din);
        model_edge(1, rst1, if1.En, if1.Din);
        #1;
        check("tx4",   32'(if4.TxD),   32'(exp_tx(0)));
        check("rdy4",  32'(if4.Ready), 32'(exp_ready(0)));
        check("bsy4",  32'(if4.Busy),  32'(!exp_ready(0)));
        check("done4", 32'(if4.Done),  32'(mdone[0]));
        check("tx1",   32'(if1.TxD),   32'(exp_tx(1)));
        check("rdy1",  32'(if1.Ready), 32'(exp_ready(1)));
        check("bsy1",  32'(if1.Busy),  32'(!exp_ready(1)));
        check("done1", 32'(if1.Done),  32'(mdone[1]));
        if (if1.Done === 1'b1) done1_times.push_back(cyc);
    endtask

    task automatic run(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    initial begin
        baud[0] = 4; baud[1] = 1;
        for (int i = 0; i < 2; i++) begin rd[i] = 0; len[i] = 0; mdone[i] = 1'b0; end

        // Reset with En high and all-ones data: no frame may start.
        rst4 = 1'b1; rst1 = 1'b1;
        if4.En = 1'b1; if4.Din = 4'b1111;
        if1.En = 1'b1; if1.Din = 4'b1111;
        run(2);
        rst4 = 1'b0; rst1 = 1'b0;
        if4.En = 1'b0; if1.En = 1'b0;
        run(3);

        // Basic frame and parity cases on the BAUD_DIV=4 instance.
        if4.En = 1'b1; if4.Din = 4'b1011; step(); if4.En = 1'b0; run(30);
        if4.En = 1'b1; if4.Din = 4'b0000; step(); if4.En = 1'b0; run(30);
        if4.En = 1'b1; if4.Din = 4'b0110; step(); if4.En = 1'b0; run(30);

        // En while busy is ignored; Din changes after acceptance are too.
        if4.En = 1'b1; if4.Din = 4'b1000; step(); if4.En = 1'b0;
        if4.Din = 4'b0101;
        run(9);
        if4.En = 1'b1; if4.Din = 4'b0111; step(); if4.En = 1'b0;
        run(25);

        // Back-to-back on the BAUD_DIV=1 instance: second En in the Done cycle.
        done1_times.delete();
        if1.En = 1'b1; if1.Din = 4'b1100; step(); if1.En = 1'b0;
        run(7);
        if1.En = 1'b1; if1.Din = 4'b0011; step(); if1.En = 1'b0;
        run(12);
        check("b2b_done_count", 32'(done1_times.size()), 32'd2);

        // Reset in the middle of DATA, then a clean new frame.
        if4.En = 1'b1; if4.Din = 4'b1110; step(); if4.En = 1'b0;
        run(9);
        rst4 = 1'b1; step(); rst4 = 1'b0;
        step();
        if4.En = 1'b1; if4.Din = 4'b1001; step(); if4.En = 1'b0;
        run(30);

        // Randomized traffic on both instances, with occasional resets.
        for (int s = 0; s < 1500; s++) begin
            if4.En  = ($urandom_range(0, 3) == 0);
            if4.Din = 4'($urandom);
            rst4    = ($urandom_range(0, 99) == 0);
            if1.En  = ($urandom_range(0, 2) == 0);
            if1.Din = 4'($urandom);
            rst1    = ($urandom_range(0, 99) == 0);
            step();
        end
        rst4 = 1'b0; rst1 = 1'b0; if4.En = 1'b0; if1.En = 1'b0;
        run(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
